// File: rtl/uart_inst_loader_pkg.sv
// Shared types and constants for the UART program loader: FSM encodings,
// the bit-period helper and the image-format constants.
package uart_inst_loader_pkg;

    typedef enum logic [1:0] {
        S_LEN_HI = 2'd0,
        S_LEN_LO = 2'd1,
        S_DATA   = 2'd2,
        S_DONE   = 2'd3
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned HDR_BYTES      = 32'd2;
    localparam int unsigned BYTES_PER_WORD = 32'd4;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_inst_loader_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting
// start-bit check, one-cycle rx_valid / frame_err_pulse outputs.
module uart_rx_byte
    import uart_inst_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 32'd16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err_pulse
);

    localparam logic [31:0] HALF_M1 = 32'(CLKS_PER_BIT / 32'd2 - 32'd1);
    localparam logic [31:0] FULL_M1 = 32'(CLKS_PER_BIT - 32'd1);

    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t   state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        valid_q, valid_d;
    logic [7:0]  byte_q, byte_d;
    logic        ferr_q, ferr_d;

    // Synchronizer and receiver state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= 32'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            valid_q   <= 1'b0;
            byte_q    <= 8'd0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            byte_q    <= byte_d;
            ferr_q    <= ferr_d;
        end
    end

    // Bit timing and deserializer next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        byte_d  = byte_q;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = 32'd0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                // A line that is high again at mid start bit was only a glitch
                if (cnt_q == HALF_M1) begin
                    cnt_d   = 32'd0;
                    bit_d   = 3'd0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = 32'd0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = 32'd0;
                    state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end else begin
                    state_d = RX_STOP;
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = 32'd0;
            end
        endcase
    end

    assign rx_valid        = valid_q;
    assign rx_byte         = byte_q;
    assign frame_err_pulse = ferr_q;

endmodule

// File: rtl/uart_inst_loader.sv
// Boot loader: parses a length-prefixed big-endian image from the UART and
// writes 32-bit words into instruction memory, then raises recv_done.
module uart_inst_loader
    import uart_inst_loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 32'd100_000_000,
    parameter int unsigned BAUD      = 32'd9600,
    parameter int unsigned MEM_DEPTH = 32'd512,
    parameter int unsigned TIMEOUT   = CLK_FREQ / 32'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic [15:0] uart_addr,
    output logic        uart_wr_en,
    output logic [31:0] uart_wdata,
    output logic        recv_done,
    output logic        frame_err
);

    localparam int unsigned CPB     = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [31:0] TO_M1   = 32'(TIMEOUT - 32'd1);
    localparam logic [1:0]  LAST_BI = 2'(BYTES_PER_WORD - 32'd1);

    logic        rx_valid_s, frame_err_pulse_s, timeout_s;
    logic [7:0]  rx_byte_s;
    logic [31:0] next_word_s;

    load_state_t state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] n_q, n_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] idle_q, idle_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_en_q, wr_en_d;
    logic        recv_done_q, recv_done_d;
    logic        frame_err_q, frame_err_d;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk             (clk),
        .reset           (reset),
        .rx              (uart_rx),
        .rx_valid        (rx_valid_s),
        .rx_byte         (rx_byte_s),
        .frame_err_pulse (frame_err_pulse_s)
    );

    assign next_word_s = {word_q[23:0], rx_byte_s};
    assign timeout_s   = (idle_q == TO_M1) && !rx_valid_s;

    // Loader state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_LEN_HI;
            len_hi_q    <= 8'd0;
            n_q         <= 16'd0;
            byte_idx_q  <= 2'd0;
            word_cnt_q  <= 16'd0;
            word_q      <= 32'd0;
            idle_q      <= 32'd0;
            addr_q      <= 16'd0;
            wdata_q     <= 32'd0;
            wr_en_q     <= 1'b0;
            recv_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            n_q         <= n_d;
            byte_idx_q  <= byte_idx_d;
            word_cnt_q  <= word_cnt_d;
            word_q      <= word_d;
            idle_q      <= idle_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_en_q     <= wr_en_d;
            recv_done_q <= recv_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Header/word FSM, write-port generation and idle timeout
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        n_d         = n_q;
        byte_idx_d  = byte_idx_q;
        word_cnt_d  = word_cnt_q;
        word_d      = word_q;
        idle_d      = 32'd0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_en_d     = 1'b0;
        recv_done_d = recv_done_q | (state_q == S_DONE);
        frame_err_d = frame_err_q | frame_err_pulse_s;
        case (state_q)
            S_LEN_HI: begin
                if (rx_valid_s) begin
                    len_hi_d = rx_byte_s;
                    state_d  = S_LEN_LO;
                end else begin
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_LO: begin
                idle_d = idle_q + 32'd1;
                if (rx_valid_s) begin
                    idle_d = 32'd0;
                    n_d    = {len_hi_q, rx_byte_s};
                    if ({len_hi_q, rx_byte_s} == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        byte_idx_d = 2'd0;
                        word_cnt_d = 16'd0;
                        state_d    = S_DATA;
                    end
                end else if (timeout_s) begin
                    idle_d     = 32'd0;
                    byte_idx_d = 2'd0;
                    word_cnt_d = 16'd0;
                    state_d    = S_LEN_HI;
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_DATA: begin
                idle_d = idle_q + 32'd1;
                if (rx_valid_s) begin
                    idle_d     = 32'd0;
                    word_d     = next_word_s;
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Fourth byte completes a word; words past MEM_DEPTH are consumed but not written
                    if (byte_idx_q == LAST_BI) begin
                        wdata_d    = next_word_s;
                        addr_d     = word_cnt_q + 16'd1;
                        wr_en_d    = ({16'd0, word_cnt_q} < MEM_DEPTH);
                        word_cnt_d = word_cnt_q + 16'd1;
                        state_d    = ((word_cnt_q + 16'd1) == n_q) ? S_DONE : S_DATA;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (timeout_s) begin
                    idle_d     = 32'd0;
                    byte_idx_d = 2'd0;
                    word_cnt_d = 16'd0;
                    state_d    = S_LEN_HI;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_LEN_HI;
            end
        endcase
    end

    assign uart_addr  = addr_q;
    assign uart_wr_en = wr_en_q;
    assign uart_wdata = wdata_q;
    assign recv_done  = recv_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Directed + randomized bench: drives serial images and compares memory writes
// against a list of writes derived from the image format.
module tb_uart_inst_loader;
    import uart_inst_loader_pkg::*;

    localparam int unsigned CLK_FREQ  = 100_000_000;
    localparam int unsigned BAUD      = 6_250_000;
    localparam int unsigned MEM_DEPTH = 4;
    localparam int unsigned TIMEOUT   = 3000;
    localparam int          BIT_T     = 160;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic [15:0] uart_addr;
    logic        uart_wr_en;
    logic [31:0] uart_wdata;
    logic        recv_done;
    logic        frame_err;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int rxv_cnt = 0;
    int last_rxv = 0;
    int done_cyc = -1;
    logic done_prev = 1'b0;
    logic [15:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          lat_q[$];
    logic [7:0]  img_q[$];

    uart_inst_loader #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .MEM_DEPTH (MEM_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .uart_addr  (uart_addr),
        .uart_wr_en (uart_wr_en),
        .uart_wdata (uart_wdata),
        .recv_done  (recv_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (u_dut.rx_valid_s === 1'b1) begin
            rxv_cnt  = rxv_cnt + 1;
            last_rxv = cyc;
        end
        if (uart_wr_en === 1'b1) begin
            wa_q.push_back(uart_addr);
            wd_q.push_back(uart_wdata);
            lat_q.push_back(cyc - last_rxv);
        end
        if (recv_done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
        done_prev = recv_done;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        #BIT_T;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            #BIT_T;
        end
        uart_rx = stop_bit;
        #BIT_T;
        uart_rx = 1'b1;
        #BIT_T;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"},  32'(uart_addr), 32'd0);
        chk({tag, "_wr_en"}, 32'(uart_wr_en), 32'd0);
        chk({tag, "_wdata"}, uart_wdata, 32'd0);
        chk({tag, "_done"},  32'(recv_done), 32'd0);
        chk({tag, "_ferr"},  32'(frame_err), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_zero(tag);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        lat_q.delete();
        done_cyc = -1;
    endtask

    task automatic rand_image(input int n);
        img_q.delete();
        img_q.push_back(8'(n >> 8));
        img_q.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) img_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference: word k of the image is bytes HDR+4k..HDR+4k+3, MSB first, written at k+1 if k < MEM_DEPTH
    task automatic load_and_check(input string tag);
        int n, exp_wr, rxv0;
        logic [31:0] exp_w;
        clear_mon();
        rxv0 = rxv_cnt;
        foreach (img_q[i]) send_byte(img_q[i], 1'b1);
        for (int i = 0; i < 100 && recv_done !== 1'b1; i++) @(negedge clk);
        n = (int'(img_q[0]) << 8) | int'(img_q[1]);
        exp_wr = (n < int'(MEM_DEPTH)) ? n : int'(MEM_DEPTH);
        chk({tag, "_done"}, 32'(recv_done), 32'd1);
        chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
        chk({tag, "_wr_count"}, 32'(wa_q.size()), 32'(exp_wr));
        chk({tag, "_bytes"}, 32'(rxv_cnt - rxv0), 32'(img_q.size()));
        chk({tag, "_done_lat"}, 32'(done_cyc - last_rxv), 32'd2);
        for (int k = 0; k < exp_wr && k < wa_q.size(); k++) begin
            exp_w = {img_q[HDR_BYTES + 4*k], img_q[HDR_BYTES + 4*k + 1],
                     img_q[HDR_BYTES + 4*k + 2], img_q[HDR_BYTES + 4*k + 3]};
            chk($sformatf("%s_addr%0d", tag, k), 32'(wa_q[k]), 32'(k + 1));
            chk($sformatf("%s_data%0d", tag, k), wd_q[k], exp_w);
            chk($sformatf("%s_lat%0d", tag, k), 32'(lat_q[k]), 32'd1);
        end
    endtask

    initial begin
        int rx0, n;
        repeat (4) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // quarter-bit glitch while idle
        rx0 = rxv_cnt;
        uart_rx = 1'b0;
        #(BIT_T / 4);
        uart_rx = 1'b1;
        #(BIT_T * 12);
        chk("glitch_rxv", 32'(rxv_cnt - rx0), 32'd0);
        chk("glitch_ferr", 32'(frame_err), 32'd0);

        img_q = '{8'h00, 8'h02, 8'h20, 8'h10, 8'h00, 8'h50, 8'h20, 8'h11, 8'h03, 8'h20};
        load_and_check("two_word");

        do_reset("rst1");
        img_q = '{8'h00, 8'h00};
        load_and_check("empty");

        // frame error inside data, then timeout and a clean reload
        do_reset("rst2");
        clear_mon();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h33, 1'b1);
        repeat (TIMEOUT + 50) @(negedge clk);
        chk("ferr_set", 32'(frame_err), 32'd1);
        chk("ferr_no_write", 32'(wa_q.size()), 32'd0);
        chk("ferr_not_done", 32'(recv_done), 32'd0);
        clear_mon();
        foreach (img_q[i]) img_q.delete();
        img_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        foreach (img_q[i]) send_byte(img_q[i], 1'b1);
        for (int i = 0; i < 100 && recv_done !== 1'b1; i++) @(negedge clk);
        chk("retry_done", 32'(recv_done), 32'd1);
        chk("retry_count", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() > 0) begin
            chk("retry_addr", 32'(wa_q[0]), 32'd1);
            chk("retry_data", wd_q[0], 32'hDEADBEEF);
        end
        chk("retry_ferr_sticky", 32'(frame_err), 32'd1);

        // more words than memory depth
        do_reset("rst3");
        rand_image(6);
        load_and_check("overflow");

        // reset mid-word with live outputs
        do_reset("rst4");
        rand_image(2);
        for (int i = 0; i < 8; i++) send_byte(img_q[i], 1'b1);
        chk("mid_pre_addr", 32'(uart_addr), 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("mid_async");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        rand_image(2);
        load_and_check("after_mid");

        for (int r = 0; r < 3; r++) begin
            do_reset($sformatf("rst_r%0d", r));
            n = int'($urandom_range(1, 5));
            rand_image(n);
            load_and_check($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
